// File: rtl/esn_predict.sv
// Purpose : ESN test-phase readout; est = sat32((sum W[k]*X[k]) >>> FRAC) via one serial MAC.
// Latency : state accepted at edge t -> est_valid pulse in cycle t+N+1; next state at edge t+N+2.
// Backpressure: xs_ready low while busy (states are not buffered); est_valid is a one-cycle pulse, never held.
//
// Ports:
//   clk        rising-edge clock
//   rst_N      synchronous reset, active HIGH (1 = reset) despite the name
//   w_load     one-cycle strobe capturing W_in (shadowed while a computation runs)
//   W_in       packed weights, element i = W_in[i*WW +: WW]
//   xs_valid   XSTATE valid; accepted only while xs_ready is high
//   XSTATE     packed extended state, element i = XSTATE[i*XW +: XW]
//   xs_ready   block can accept a state this cycle
//   est_valid  one-cycle pulse, est has a new value
//   est        saturated prediction, held between pulses
//   busy       MAC or DONE in progress
module esn_predict #(
    parameter int N    = 8,
    parameter int WW   = 32,
    parameter int XW   = 16,
    parameter int FRAC = 15
) (
    input  logic            clk,
    input  logic            rst_N,
    input  logic            w_load,
    input  logic [N*WW-1:0] W_in,
    input  logic            xs_valid,
    input  logic [N*XW-1:0] XSTATE,
    output logic            xs_ready,
    output logic            est_valid,
    output logic [31:0]     est,
    output logic            busy
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = WW + XW;
    localparam int AW = PW + $clog2(N);

    // Saturation limits expressed at accumulator width.
    localparam logic signed [AW-1:0] MAXV = {{(AW-32){1'b0}}, 32'h7FFF_FFFF};
    localparam logic signed [AW-1:0] MINV = {{(AW-32){1'b1}}, 32'h8000_0000};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [KW-1:0]          k_q;
    logic signed [AW-1:0]   acc_q;
    logic [N*WW-1:0]        w_q;
    logic [N*WW-1:0]        shadow_q;
    logic                   pend_q;
    logic [N*XW-1:0]        x_q;
    logic [31:0]            est_q;
    logic                   est_vld_q;
    logic                   busy_q;
    logic                   rdy_q;

    // Current MAC operands, product and sign-extended product.
    logic signed [WW-1:0]   w_k;
    logic signed [XW-1:0]   x_k;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   shifted;
    logic [31:0]            sat;

    always_comb begin
        w_k      = w_q[int'(k_q)*WW +: WW];
        x_k      = x_q[int'(k_q)*XW +: XW];
        prod     = w_k * x_k;
        prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
        shifted  = acc_q >>> FRAC;
        if (shifted > MAXV) begin
            sat = 32'h7FFF_FFFF;
        end else if (shifted < MINV) begin
            sat = 32'h8000_0000;
        end else begin
            sat = shifted[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_N) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            acc_q     <= '0;
            w_q       <= '0;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            x_q       <= '0;
            est_q     <= '0;
            est_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            est_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A weight load in the accept cycle lands before the first MAC reads w_q.
                    if (w_load) begin
                        w_q <= W_in;
                    end
                    if (xs_valid && rdy_q) begin
                        x_q     <= XSTATE;
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= S_MAC;
                        busy_q  <= 1'b1;
                        rdy_q   <= 1'b0;
                    end else begin
                        busy_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (w_load) begin
                        shadow_q <= W_in;
                        pend_q   <= 1'b1;
                    end
                    acc_q <= acc_q + prod_ext;
                    k_q   <= k_q + KW'(1);
                    if (k_q == KW'(N-1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    est_q     <= sat;
                    est_vld_q <= 1'b1;
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    rdy_q     <= 1'b1;
                    pend_q    <= 1'b0;
                    // A fresh load on the commit edge beats the older shadow copy.
                    if (w_load) begin
                        w_q <= W_in;
                    end else if (pend_q) begin
                        w_q <= shadow_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign xs_ready  = rdy_q;
    assign est_valid = est_vld_q;
    assign est       = est_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_esn_predict.sv
module tb_esn_predict;

    localparam int N  = 8;
    localparam int WW = 32;
    localparam int XW = 16;

    logic            clk;
    logic            rst_N;
    logic            w_load;
    logic [N*WW-1:0] W_in;
    logic            xs_valid;
    logic [N*XW-1:0] XSTATE;
    logic            xs_ready;
    logic            est_valid;
    logic [31:0]     est;
    logic            busy;

    int total;
    int bad;

    esn_predict #(.N(N), .WW(WW), .XW(XW), .FRAC(15)) dut (
        .clk       (clk),
        .rst_N     (rst_N),
        .w_load    (w_load),
        .W_in      (W_in),
        .xs_valid  (xs_valid),
        .XSTATE    (XSTATE),
        .xs_ready  (xs_ready),
        .est_valid (est_valid),
        .est       (est),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N*WW-1:0] w;
        logic [N*XW-1:0] x;
        logic [31:0]     exp;
        string           name;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int i;
        for (i = 0; i < 20; i++) begin
            if (xs_ready) break;
            step();
        end
        if (!xs_ready) begin
            total++;
            bad++;
            $display("FAIL %s_ready_timeout: xs_ready stayed low", name);
        end
    endtask

    task automatic load_w(input logic [N*WW-1:0] w);
        w_load = 1'b1;
        W_in   = w;
        step();
        w_load = 1'b0;
    endtask

    // Presents one state for one edge; returns in the first cycle after acceptance.
    task automatic send_x(input logic [N*XW-1:0] x);
        xs_valid = 1'b1;
        XSTATE   = x;
        step();
        xs_valid = 1'b0;
    endtask

    // Called in the cycle after acceptance: waits for est_valid, counts latency and busy cycles.
    task automatic wait_est(input string name, output logic [31:0] v, output int lat, output int bcnt);
        bit ok;
        ok   = 1'b0;
        lat  = 0;
        v    = '0;
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step();
            lat++;
            if (est_valid) begin
                ok = 1'b1;
                v  = est;
                break;
            end
            if (busy) bcnt++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_est_timeout: no est_valid within 40 cycles", name);
        end
    endtask

    initial begin
        logic [31:0] v;
        int lat, bcnt;
        int low_cnt, np;
        bit seen_rdy, drop_next;
        int pos[4];
        logic [31:0] val[4];
        int pulses;

        total    = 0;
        bad      = 0;
        rst_N    = 1'b1;
        w_load   = 1'b0;
        W_in     = '0;
        xs_valid = 1'b0;
        XSTATE   = '0;

        tbl[0] = '{ {8{32'h0001_0000}}, {8{16'h4000}}, 32'h0004_0000, "unit_mac" };
        tbl[1] = '{ {8{32'h7FFF_FFFF}}, {8{16'h7FFF}}, 32'h7FFF_FFFF, "sat_pos" };
        tbl[2] = '{ {8{32'h8000_0000}}, {8{16'h7FFF}}, 32'h8000_0000, "sat_neg" };
        tbl[3] = '{ {32'h0004_0000, 32'h0003_8000, 32'h0003_0000, 32'h0002_8000,
                     32'h0002_0000, 32'h0001_8000, 32'h0001_0000, 32'h0000_8000},
                    {4{16'hFFFF, 16'h0001}}, 32'hFFFF_FFFC, "index_signed" };
        tbl[4] = '{ {8{32'h0000_8000}}, {8{16'h0003}}, 32'h0000_0018, "small_sum" };
        tbl[5] = '{ {8{32'h8000_0000}}, {8{16'h8000}}, 32'h7FFF_FFFF, "neg_x_neg_sat" };
        tbl[6] = '{ {{7{32'h0}}, 32'h0000_0001}, {{7{16'h0}}, 16'hFFFF}, 32'hFFFF_FFFF, "elem0_floor" };
        tbl[7] = '{ {32'h0001_0000, {7{32'h0}}}, {16'h0002, {7{16'h0}}}, 32'h0000_0004, "elem7_last" };

        // Reset state.
        step();
        step();
        chk("rst_est", est, 32'h0);
        chk("rst_est_valid", {31'b0, est_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_xs_ready", {31'b0, xs_ready}, 32'h0);
        rst_N = 1'b0;
        step();
        chk("post_rst_xs_ready", {31'b0, xs_ready}, 32'h1);

        // Table: weights and state presented in the same IDLE cycle; the new weights must be used.
        for (int i = 0; i < 8; i++) begin
            wait_ready(tbl[i].name);
            w_load   = 1'b1;
            W_in     = tbl[i].w;
            xs_valid = 1'b1;
            XSTATE   = tbl[i].x;
            step();
            w_load   = 1'b0;
            xs_valid = 1'b0;
            wait_est(tbl[i].name, v, lat, bcnt);
            chk(tbl[i].name, v, tbl[i].exp);
            if (i == 0) begin
                chk("latency", 32'(lat), 32'd9);
                chk("busy_cycles", 32'(bcnt), 32'd9);
                step();
                chk("est_valid_one_pulse", {31'b0, est_valid}, 32'h0);
                chk("est_hold", est, 32'h0004_0000);
            end
        end

        // Weight load during MAC goes to the shadow; current result uses the old weights.
        wait_ready("shadow");
        load_w({8{32'h0001_0000}});
        send_x({8{16'h4000}});
        step();
        step();
        w_load = 1'b1;
        W_in   = '0;
        step();
        w_load = 1'b0;
        wait_est("shadow_first", v, lat, bcnt);
        chk("shadow_old_weights", v, 32'h0004_0000);
        wait_ready("shadow2");
        send_x({8{16'h4000}});
        wait_est("shadow_second", v, lat, bcnt);
        chk("shadow_committed", v, 32'h0);

        // A load on the commit edge beats the pending shadow.
        wait_ready("collide");
        load_w({8{32'h0001_0000}});
        send_x({8{16'h4000}});
        w_load = 1'b1;
        W_in   = '0;
        step();
        w_load = 1'b0;
        for (int i = 2; i <= N; i++) step();
        w_load = 1'b1;
        W_in   = {8{32'h0000_8000}};
        step();
        w_load = 1'b0;
        chk("collide_est_valid", {31'b0, est_valid}, 32'h1);
        chk("collide_est", est, 32'h0004_0000);
        wait_ready("collide2");
        send_x({8{16'h0003}});
        wait_est("collide_second", v, lat, bcnt);
        chk("collide_new_wins", v, 32'h0000_0018);

        // xs_valid held high with S0 then S1.
        wait_ready("stream");
        xs_valid  = 1'b1;
        XSTATE    = {8{16'h0003}};
        step();
        XSTATE    = {8{16'h0005}};
        low_cnt   = 0;
        seen_rdy  = 1'b0;
        drop_next = 1'b0;
        np        = 0;
        for (int c = 0; c < 30; c++) begin
            if (!seen_rdy) begin
                if (xs_ready) begin
                    seen_rdy  = 1'b1;
                    drop_next = 1'b1;
                end else begin
                    low_cnt++;
                end
            end
            if (est_valid) begin
                if (np < 4) begin
                    pos[np] = c;
                    val[np] = est;
                end
                np++;
            end
            step();
            if (drop_next) begin
                xs_valid  = 1'b0;
                drop_next = 1'b0;
            end
        end
        xs_valid = 1'b0;
        chk("stream_ready_low", 32'(low_cnt), 32'd9);
        chk("stream_pulses", 32'(np), 32'd2);
        if (np >= 2) begin
            chk("stream_first_pos", 32'(pos[0]), 32'd9);
            chk("stream_spacing", 32'(pos[1] - pos[0]), 32'd10);
            chk("stream_s0", val[0], 32'h0000_0018);
            chk("stream_s1", val[1], 32'h0000_0028);
        end

        // Reset in the middle of a computation.
        wait_ready("midrst");
        load_w({8{32'h0001_0000}});
        send_x({8{16'h4000}});
        step();
        step();
        step();
        rst_N = 1'b1;
        step();
        rst_N = 1'b0;
        chk("midrst_est", est, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        chk("midrst_ready_low", {31'b0, xs_ready}, 32'h0);
        pulses = est_valid ? 1 : 0;
        step();
        chk("midrst_ready_after", {31'b0, xs_ready}, 32'h1);
        for (int i = 0; i < 12; i++) begin
            if (est_valid) pulses++;
            step();
        end
        chk("midrst_no_pulse", 32'(pulses), 32'd0);
        wait_ready("midrst2");
        send_x({8{16'h4000}});
        wait_est("midrst_after", v, lat, bcnt);
        chk("midrst_zero_weights", v, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
